// File: rtl/next_pc_predictor_pkg.sv
// Shared types for the next-PC predictor: 2-bit direction counter encodings
// and the values loaded at reset and on allocation.
package next_pc_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_INIT      = CTR_WNT;
    localparam ctr_e CTR_ALLOC_BR  = CTR_WT;
    localparam ctr_e CTR_ALLOC_JAL = CTR_ST;

endpackage

// File: rtl/next_pc_predictor_if.sv
// Fetch lookup, execute training and perf-counter signals of the predictor.
// master drives fetch/execute inputs, slave is the predictor itself.
interface next_pc_predictor_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 F_valid_i;
    logic [PC_WIDTH-1:0]  F_PC_i;
    logic [PC_WIDTH-1:0]  nPC_o;
    logic                 F_hit_o;
    logic                 F_pred_taken_o;
    logic                 flush_i;
    logic                 E_update_i;
    logic [PC_WIDTH-1:0]  E_PC_i;
    logic                 E_is_jal_i;
    logic                 E_taken_i;
    logic [PC_WIDTH-1:0]  E_target_i;
    logic [PC_WIDTH-1:0]  E_pred_npc_i;
    logic                 E_mispredict_o;
    logic [CNT_WIDTH-1:0] hit_cnt_o;
    logic [CNT_WIDTH-1:0] mispred_cnt_o;

    modport master (
        output F_valid_i, F_PC_i, flush_i, E_update_i, E_PC_i, E_is_jal_i,
               E_taken_i, E_target_i, E_pred_npc_i,
        input  nPC_o, F_hit_o, F_pred_taken_o, E_mispredict_o, hit_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  F_valid_i, F_PC_i, flush_i, E_update_i, E_PC_i, E_is_jal_i,
               E_taken_i, E_target_i, E_pred_npc_i,
        output nPC_o, F_hit_o, F_pred_taken_o, E_mispredict_o, hit_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/next_pc_predictor_sat_counter2.sv
// Next-value logic for a 2-bit saturating direction counter.
module next_pc_predictor_sat_counter2
    import next_pc_predictor_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_inc,
    output ctr_e o_next
);

    always_comb begin
        o_next = i_ctr;
        if (i_inc) begin
            if (i_ctr != CTR_ST) o_next = ctr_e'(i_ctr + 2'd1);
        end else begin
            if (i_ctr != CTR_SNT) o_next = ctr_e'(i_ctr - 2'd1);
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// Direct-mapped BTB next-PC predictor: zero-latency fetch lookup, execute-stage
// training with mispredict detection, and saturating hit/mispredict counters.
module next_pc_predictor
    import next_pc_predictor_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int ENTRIES   = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic clk_i,
    input  logic rst,
    next_pc_predictor_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - 2 - IDX_W;

    logic [ENTRIES-1:0]  r_valid;
    ctr_e                r_ctr    [ENTRIES];
    logic                r_jal    [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0] r_target [ENTRIES];
    logic [CNT_WIDTH-1:0] r_hit_cnt;
    logic [CNT_WIDTH-1:0] r_mispred_cnt;

    logic [IDX_W-1:0]    w_f_idx;
    logic [TAG_W-1:0]    w_f_tag;
    logic                w_f_hit;
    logic                w_f_pred;
    logic [IDX_W-1:0]    w_e_idx;
    logic [TAG_W-1:0]    w_e_tag;
    logic                w_e_hit;
    logic                w_upd;
    logic [PC_WIDTH-1:0] w_actual;
    logic                w_mispredict;
    ctr_e                w_ctr_next;

    assign w_f_idx  = bus.F_PC_i[IDX_W+1:2];
    assign w_f_tag  = bus.F_PC_i[PC_WIDTH-1:IDX_W+2];
    assign w_f_hit  = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_pred = w_f_hit && (r_jal[w_f_idx] || r_ctr[w_f_idx][1]);

    assign bus.F_hit_o        = w_f_hit;
    assign bus.F_pred_taken_o = w_f_pred;
    assign bus.nPC_o          = w_f_pred ? r_target[w_f_idx] : bus.F_PC_i + PC_WIDTH'(4);

    assign w_actual     = bus.E_taken_i ? bus.E_target_i : bus.E_PC_i + PC_WIDTH'(4);
    assign w_mispredict = bus.E_update_i && (w_actual != bus.E_pred_npc_i);
    assign bus.E_mispredict_o = w_mispredict;

    assign w_e_idx = bus.E_PC_i[IDX_W+1:2];
    assign w_e_tag = bus.E_PC_i[PC_WIDTH-1:IDX_W+2];
    assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
    // Flush takes priority, so a same-cycle update never lands in the table.
    assign w_upd   = bus.E_update_i && !bus.flush_i;

    next_pc_predictor_sat_counter2 u_sat (
        .i_ctr  (r_ctr[w_e_idx]),
        .i_inc  (bus.E_taken_i),
        .o_next (w_ctr_next)
    );

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
        end else if (bus.flush_i) begin
            r_valid <= '0;
        end else if (w_upd) begin
            if (w_e_hit) begin
                r_ctr[w_e_idx] <= w_ctr_next;
            end else if (bus.E_taken_i) begin
                r_valid[w_e_idx] <= 1'b1;
                r_ctr[w_e_idx]   <= bus.E_is_jal_i ? CTR_ALLOC_JAL : CTR_ALLOC_BR;
            end
        end
    end

    // Payload is only observable through a valid entry, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_upd && (w_e_hit || bus.E_taken_i)) begin
            r_jal[w_e_idx] <= bus.E_is_jal_i;
            if (bus.E_taken_i) r_target[w_e_idx] <= bus.E_target_i;
            if (!w_e_hit)      r_tag[w_e_idx]    <= w_e_tag;
        end
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_hit_cnt     <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (bus.F_valid_i && w_f_hit && (r_hit_cnt != '1))
                r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
            if (w_mispredict && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.hit_cnt_o     = r_hit_cnt;
    assign bus.mispred_cnt_o = r_mispred_cnt;

endmodule
